// File: rtl/hamming_enc_arbiter.sv
// Round-robin front end that lets NUM_CH requesters share one pulse-driven
// 16->21 Hamming encoder and returns each codeword tagged with its channel ID.
module hamming_enc_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    req_valid,
    input  logic [NUM_CH*16-1:0] req_data,
    output logic [NUM_CH-1:0]    req_ready,
    output logic [15:0]          enc_data,
    output logic                 enc_valid,
    input  logic                 enc_rdy,
    output logic                 enc_take,
    input  logic [20:0]          enc_code,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [20:0]          out_data,
    output logic [ID_W-1:0]      out_id,
    output logic                 err_timeout,
    output logic                 busy
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, TAKE, OUT} state_t;

    state_t          state, stateNext;
    logic [ID_W-1:0] rrPtr;
    logic [ID_W-1:0] grantId;
    logic            grantHit;
    logic [TO_W-1:0] toCnt;
    logic [15:0]     chWord [NUM_CH];

    for (genvar k = 0; k < NUM_CH; k++) begin : gCh
        assign chWord[k] = req_data[16*k +: 16];
    end

    // First requester strictly after the last grant, wrapping.
    always_comb begin : rrPick
        int c;
        logic [ID_W-1:0] idx;
        c        = 0;
        idx      = '0;
        grantHit = 1'b0;
        grantId  = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            c   = (int'(rrPtr) + i) % NUM_CH;
            idx = ID_W'(c);
            if (!grantHit && req_valid[idx]) begin
                grantHit = 1'b1;
                grantId  = idx;
            end
        end
    end

    always_comb begin
        stateNext   = state;
        req_ready   = '0;
        enc_valid   = 1'b0;
        enc_take    = 1'b0;
        out_valid   = 1'b0;
        err_timeout = 1'b0;
        busy        = (state != IDLE);
        case (state)
            IDLE: begin
                // Gated by rst so nothing is acknowledged while held in reset.
                if (grantHit && rst) begin
                    req_ready[grantId] = 1'b1;
                    stateNext          = ISSUE;
                end
            end
            ISSUE: begin
                enc_valid = 1'b1;
                stateNext = WAIT;
            end
            WAIT: begin
                if (enc_rdy) begin
                    stateNext = TAKE;
                end else if (toCnt == TO_W'(TIMEOUT - 1)) begin
                    err_timeout = 1'b1;
                    stateNext   = IDLE;
                end
            end
            TAKE: begin
                enc_take  = 1'b1;
                stateNext = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            rrPtr    <= ID_W'(NUM_CH - 1);
            enc_data <= '0;
            out_data <= '0;
            out_id   <= '0;
            toCnt    <= '0;
        end else begin
            state <= stateNext;
            if (req_ready != '0) begin
                enc_data <= chWord[grantId];
                out_id   <= grantId;
                rrPtr    <= grantId;
            end
            // Counter value in WAIT is the number of WAIT cycles already spent.
            if (state == ISSUE)     toCnt <= '0;
            else if (state == WAIT) toCnt <= toCnt + 1'b1;
            if (enc_take) out_data <= enc_code;
        end
    end

endmodule

// File: tb/tb_hamming_enc_arbiter.sv
// Randomized bench for hamming_enc_arbiter: an encoder stub plus a
// transaction-level scoreboard for grant order, codewords and timeouts.
module tb_hamming_enc_arbiter;
    localparam int NUM_CH  = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 15;
    localparam int TO_W    = 4;
    localparam int BUF     = 512;

    logic                 clk;
    logic                 rst;
    logic [NUM_CH-1:0]    req_valid;
    logic [NUM_CH*16-1:0] req_data;
    logic [NUM_CH-1:0]    req_ready;
    logic [15:0]          enc_data;
    logic                 enc_valid;
    logic                 enc_rdy;
    logic                 enc_take;
    logic [20:0]          enc_code;
    logic                 out_valid;
    logic                 out_ready;
    logic [20:0]          out_data;
    logic [ID_W-1:0]      out_id;
    logic                 err_timeout;
    logic                 busy;

    hamming_enc_arbiter #(.NUM_CH(NUM_CH), .ID_W(ID_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .enc_data(enc_data), .enc_valid(enc_valid), .enc_rdy(enc_rdy), .enc_take(enc_take),
        .enc_code(enc_code), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_id(out_id), .err_timeout(err_timeout), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Textbook Hamming: parity at positions 1,2,4,8,16; data fills the rest in order.
    function automatic logic [20:0] ham(input logic [15:0] d);
        logic [21:0] c;
        logic        par;
        int          j;
        c = '0;
        j = 0;
        for (int p = 1; p <= 21; p++)
            if ((p & (p - 1)) != 0) begin c[p] = d[j]; j++; end
        for (int i = 0; i < 5; i++) begin
            par = 1'b0;
            for (int p = 1; p <= 21; p++) if ((p & (1 << i)) != 0) par ^= c[p];
            c[1 << i] = par;
        end
        return c[21:1];
    endfunction

    function automatic int modelPick(input logic [NUM_CH-1:0] v, input int ptr);
        for (int i = 1; i <= NUM_CH; i++)
            if (v[(ptr + i) % NUM_CH]) return (ptr + i) % NUM_CH;
        return -1;
    endfunction

    typedef struct { logic [ID_W-1:0] id; logic [20:0] code; } exp_t;

    int          nErr, nChecks, cyc;
    exp_t        expQ[$];
    int          dutGrants[$];
    logic [15:0] chBuf [NUM_CH][BUF];
    int          head [NUM_CH];
    int          tail [NUM_CH];
    int          modelPtr;
    bit          modelIdle;
    int          issueCyc, nIssue, nTake, nTimeout, nOut, gapViol;
    bit          prevEncV, prevOV, prevOR;
    logic [20:0] heldData;
    logic [ID_W-1:0] heldId;
    bit          stubStuck, stubPend;
    int          stubDly;
    logic [15:0] stubWord;
    int          orMode;

    assign enc_code = enc_take ? ham(stubWord) : 21'd0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        nChecks++;
        if (got !== want) begin
            nErr++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic enqueue(input int k, input logic [15:0] w);
        chBuf[k][tail[k] % BUF] = w;
        tail[k]++;
    endtask

    task automatic drive();
        for (int k = 0; k < NUM_CH; k++) begin
            req_valid[k] = (head[k] != tail[k]);
            req_data[16*k +: 16] = chBuf[k][head[k] % BUF];
        end
    endtask

    function automatic bit pending();
        for (int k = 0; k < NUM_CH; k++) if (head[k] != tail[k]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic resetModel();
        expQ.delete();
        modelPtr  = NUM_CH - 1;
        modelIdle = 1'b1;
        prevOV    = 1'b0;
        prevOR    = 1'b0;
        prevEncV  = 1'b0;
    endtask

    task automatic monitor();
        logic [NUM_CH-1:0] expReady;
        int   pick;
        exp_t e;
        expReady = '0;
        pick     = modelIdle ? modelPick(req_valid, modelPtr) : -1;
        if (pick >= 0) expReady[pick] = 1'b1;
        chk("reqReady", 64'(req_ready), 64'(expReady));
        chk("busy", 64'(busy), 64'(!modelIdle));
        for (int k = 0; k < NUM_CH; k++) if (req_ready[k]) dutGrants.push_back(k);
        if (pick >= 0) begin
            e.id   = ID_W'(pick);
            e.code = ham(req_data[16*pick +: 16]);
            expQ.push_back(e);
            modelPtr  = pick;
            modelIdle = 1'b0;
        end
        if (enc_valid) begin
            issueCyc = cyc;
            nIssue++;
            if (prevEncV) gapViol++;
        end
        prevEncV = enc_valid;
        if (enc_take) begin
            nTake++;
            chk("takeRdy", 64'(enc_rdy), 64'(1));
        end
        if (err_timeout) begin
            nTimeout++;
            chk("toDelay", 64'(cyc - issueCyc), 64'(TIMEOUT));
            chk("toStuck", 64'(stubStuck), 64'(1));
            if (expQ.size() > 0) void'(expQ.pop_front());
            modelIdle = 1'b1;
        end
        if (out_valid) begin
            if (prevOV && !prevOR) begin
                chk("holdData", 64'(out_data), 64'(heldData));
                chk("holdId", 64'(out_id), 64'(heldId));
            end
            heldData = out_data;
            heldId   = out_id;
            if (out_ready) begin
                chk("outQ", 64'(expQ.size() > 0), 64'(1));
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    chk("outId", 64'(out_id), 64'(e.id));
                    chk("outData", 64'(out_data), 64'(e.code));
                end
                nOut++;
                modelIdle = 1'b1;
            end
        end
        prevOV = out_valid;
        prevOR = out_ready;
    endtask

    task automatic step();
        logic [NUM_CH-1:0] accMask;
        bit sawV, sawT;
        logic [15:0] sawData;
        @(negedge clk);
        cyc++;
        if (rst) monitor();
        else chk("rstReady", 64'(req_ready), 64'(0));
        accMask = req_ready;
        sawV    = enc_valid;
        sawT    = enc_take;
        sawData = enc_data;
        @(posedge clk);
        #1;
        for (int k = 0; k < NUM_CH; k++) if (accMask[k]) head[k]++;
        drive();
        if (!rst) begin
            stubPend = 1'b0;
            enc_rdy  = 1'b0;
        end else begin
            if (sawT) enc_rdy = 1'b0;
            if (sawV && !stubStuck) begin
                stubWord = sawData;
                stubPend = 1'b1;
                stubDly  = $urandom_range(1, 4);
            end else if (stubPend) begin
                stubDly--;
                if (stubDly == 0) begin enc_rdy = 1'b1; stubPend = 1'b0; end
            end
        end
        case (orMode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((pending() || !modelIdle) && n < budget) begin step(); n++; end
        chk("drain", 64'(!(pending() || !modelIdle)), 64'(1));
    endtask

    task automatic checkOutsZero(input string tag);
        chk(tag, 64'({req_ready, enc_data, enc_valid, enc_take, out_valid, out_data,
                      out_id, err_timeout, busy}), 64'(0));
    endtask

    initial begin : main
        int base, baseT, baseO, n;
        nErr = 0; nChecks = 0; cyc = 0;
        nIssue = 0; nTake = 0; nTimeout = 0; nOut = 0; gapViol = 0;
        stubStuck = 1'b0; stubPend = 1'b0; stubDly = 0; stubWord = '0;
        enc_rdy = 1'b0; out_ready = 1'b1; orMode = 0;
        for (int k = 0; k < NUM_CH; k++) begin head[k] = 0; tail[k] = 0; end
        resetModel();
        rst = 1'b0;
        drive();
        #1;
        checkOutsZero("resetOuts");
        repeat (3) step();
        rst = 1'b1;

        // Fairness straight after reset: two full rounds, grant order 0..3,0..3.
        dutGrants.delete();
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < NUM_CH; k++) enqueue(k, 16'hA000 + 16'(k));
        drive();
        drain(400);
        chk("rrCount", 64'(dutGrants.size()), 64'(2 * NUM_CH));
        for (int i = 0; i < dutGrants.size() && i < 2 * NUM_CH; i++)
            chk("rrOrder", 64'(dutGrants[i]), 64'(i % NUM_CH));

        // Single request on channel 2.
        base = nIssue; baseT = nTake; baseO = nOut;
        dutGrants.delete();
        enqueue(2, 16'h0001);
        drain(100);
        step();
        chk("sglGrant", 64'(dutGrants.size() == 1 && dutGrants[0] == 2), 64'(1));
        chk("sglIssue", 64'(nIssue - base), 64'(1));
        chk("sglTake", 64'(nTake - baseT), 64'(1));
        chk("sglOut", 64'(nOut - baseO), 64'(1));
        chk("sglIdle", 64'(busy), 64'(0));

        // Backpressure: stall OUT for 10 cycles with another channel waiting.
        orMode = 2;
        enqueue(3, 16'h5A5A);
        enqueue(0, 16'h1234);
        drive();
        n = 0;
        while (!out_valid && n < 50) begin step(); n++; end
        chk("bpReach", 64'(out_valid), 64'(1));
        base = nOut;
        repeat (10) step();
        chk("bpHeld", 64'(nOut - base), 64'(0));
        orMode = 0;
        drain(100);

        // Timeout with a dead encoder, then normal service.
        stubStuck = 1'b1;
        base = nTimeout; baseT = nTake; baseO = nOut;
        enqueue(1, 16'hDEAD);
        drive();
        drain(100);
        chk("toCount", 64'(nTimeout - base), 64'(1));
        chk("toNoTake", 64'(nTake - baseT), 64'(0));
        chk("toNoOut", 64'(nOut - baseO), 64'(0));
        stubStuck = 1'b0;
        enqueue(0, 16'hBEEF);
        drive();
        drain(100);
        chk("toRecover", 64'(nOut - baseO), 64'(1));

        // Reset in the middle of WAIT.
        stubStuck = 1'b1;
        for (int k = 0; k < NUM_CH; k++) enqueue(k, 16'h7000 + 16'(k));
        drive();
        base = nIssue; n = 0;
        while (nIssue == base && n < 50) begin step(); n++; end
        chk("rstReachWait", 64'(nIssue - base), 64'(1));
        repeat (3) step();
        #2;
        rst = 1'b0;
        #1;
        checkOutsZero("rstMidOuts");
        resetModel();
        for (int k = 0; k < NUM_CH; k++) begin head[k] = tail[k]; enqueue(k, 16'h7100 + 16'(k)); end
        drive();
        stubStuck = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        dutGrants.delete();
        drain(400);
        chk("rstFirstGrant", 64'(dutGrants.size() > 0 ? dutGrants[0] : -1), 64'(0));

        // Codeword sweep through channel 1, random backpressure.
        orMode = 1;
        baseO = nOut;
        enqueue(1, 16'h0000);
        enqueue(1, 16'hFFFF);
        enqueue(1, 16'h8000);
        for (int i = 0; i < 100; i++) enqueue(1, 16'($urandom));
        drive();
        drain(4000);
        chk("sweepCount", 64'(nOut - baseO), 64'(103));

        // Random multi-channel traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                enqueue($urandom_range(0, NUM_CH - 1), 16'($urandom));
                drive();
            end
            step();
        end
        drain(4000);

        chk("encValidGap", 64'(gapViol), 64'(0));
        chk("expQEmpty", 64'(expQ.size()), 64'(0));
        chk("timeoutTotal", 64'(nTimeout), 64'(1));
        $display("Result: errors=%0d of %0d checks", nErr, nChecks);
        $finish;
    end

endmodule
